// File: rtl/inst_dispatch.sv
// -----------------------------------------------------------------------------
// inst_dispatch
//   Pops one instruction word at a time from the instruction FIFO, latches its
//   control fields, starts the ILC/BSR (and the W2C when the word asks for
//   write-back), then waits for every started unit to finish before popping
//   the next word.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   run                  level enable for fetching new words
//   instruct, inst_empty FIFO head word and empty flag
//   inst_req             pop strobe (combinational)
//   ilc_start/ilc_done   start pulse / completion pulse, ILC+BSR
//   w2c_start/w2c_done   start pulse / completion pulse, W2C
//   ilc_* .. bias_shift  decoded fields of the current instruction
//   busy                 not in IDLE
//   inst_cnt             completed-instruction counter (wraps)
//   idle_empty           IDLE with nothing left in the FIFO
//
// INST_LEN must be at least 137; bits above 136 are not decoded.
// -----------------------------------------------------------------------------
module inst_dispatch #(
    parameter int INST_LEN = 256,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [INST_LEN-1:0] instruct,
    input  logic                inst_empty,
    output logic                inst_req,
    output logic                ilc_start,
    input  logic                ilc_done,
    output logic                w2c_start,
    input  logic                w2c_done,
    output logic [35:0]         ilc_st_addr,
    output logic                ilc_ispad,
    output logic [8:0]          ilc_linelen,
    output logic [3:0]          bsr_iszero,
    output logic [7:0]          bsr_buffermux,
    output logic                ilc_fromfifo,
    output logic                ilc_tofifo,
    output logic                is_w2c_back,
    output logic [35:0]         w2c_st_addr,
    output logic [8:0]          w2c_linelen,
    output logic                w2c_pooled,
    output logic                pooled_type,
    output logic [8:0]          wb_st_rd_addr,
    output logic [4:0]          w2c_shift_len,
    output logic [1:0]          w2c_valid_mac,
    output logic                is_bb,
    output logic [6:0]          bias_addr,
    output logic [4:0]          bias_shift,
    output logic                busy,
    output logic [CNT_W-1:0]    inst_cnt,
    output logic                idle_empty
);

    localparam int FLD_W = 137;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [FLD_W-1:0] fld;      // latched instruction bits 136:0
    logic             ilc_dn;   // sticky ILC completion
    logic             w2c_dn;   // sticky W2C completion
    logic             done_ok;

    // Upper instruction bits carry nothing this block decodes.
    generate
        if (INST_LEN > FLD_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^instruct[INST_LEN-1:FLD_W];
        end
    endgenerate

    // Held low during reset so the FIFO never loses a word to an aborted fetch.
    assign inst_req = rst_n & (state == IDLE) & run & ~inst_empty;

    // Same-cycle done pulses count, so a done landing on the exit cycle
    // needs no extra cycle to be captured first.
    assign done_ok = (ilc_dn | ilc_done) & (~fld[60] | w2c_dn | w2c_done);

    assign busy       = (state != IDLE);
    assign idle_empty = (state == IDLE) & inst_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            fld       <= '0;
            ilc_dn    <= 1'b0;
            w2c_dn    <= 1'b0;
            ilc_start <= 1'b0;
            w2c_start <= 1'b0;
            inst_cnt  <= '0;
        end else begin
            ilc_start <= 1'b0;
            w2c_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_req) begin
                        fld       <= instruct[FLD_W-1:0];
                        ilc_dn    <= 1'b0;
                        w2c_dn    <= 1'b0;
                        // Start pulses are registered so they line up with ISSUE.
                        ilc_start <= 1'b1;
                        w2c_start <= instruct[60];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ilc_done)           ilc_dn <= 1'b1;
                    if (w2c_done & fld[60]) w2c_dn <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (ilc_done)           ilc_dn <= 1'b1;
                    if (w2c_done & fld[60]) w2c_dn <= 1'b1;
                    if (done_ok) begin
                        state    <= IDLE;
                        inst_cnt <= inst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ilc_st_addr   = fld[35:0];
    assign ilc_ispad     = fld[36];
    assign ilc_linelen   = fld[45:37];
    assign bsr_iszero    = fld[49:46];
    assign bsr_buffermux = fld[57:50];
    assign ilc_fromfifo  = fld[58];
    assign ilc_tofifo    = fld[59];
    assign is_w2c_back   = fld[60];
    assign w2c_st_addr   = fld[96:61];
    assign w2c_linelen   = fld[105:97];
    assign w2c_pooled    = fld[106];
    assign pooled_type   = fld[107];
    assign wb_st_rd_addr = fld[116:108];
    assign w2c_shift_len = fld[121:117];
    assign w2c_valid_mac = fld[123:122];
    assign is_bb         = fld[124];
    assign bias_addr     = fld[131:125];
    assign bias_shift    = fld[136:132];

endmodule

// File: tb/tb_inst_dispatch.sv
// -----------------------------------------------------------------------------
// tb_inst_dispatch
//   FIFO model feeds words; each word carries its ILC/W2C response delays
//   (cycles after the ISSUE cycle, -1 = never) and the number of busy cycles
//   it should produce. Expected records go to a scoreboard queue on push and
//   are compared when ilc_start appears.
// -----------------------------------------------------------------------------
module tb_inst_dispatch;

    logic         clk;
    logic         rst_n;
    logic         run;
    logic [255:0] instruct;
    logic         inst_empty;
    logic         inst_req;
    logic         ilc_start;
    logic         ilc_done;
    logic         w2c_start;
    logic         w2c_done;
    logic [35:0]  ilc_st_addr;
    logic         ilc_ispad;
    logic [8:0]   ilc_linelen;
    logic [3:0]   bsr_iszero;
    logic [7:0]   bsr_buffermux;
    logic         ilc_fromfifo;
    logic         ilc_tofifo;
    logic         is_w2c_back;
    logic [35:0]  w2c_st_addr;
    logic [8:0]   w2c_linelen;
    logic         w2c_pooled;
    logic         pooled_type;
    logic [8:0]   wb_st_rd_addr;
    logic [4:0]   w2c_shift_len;
    logic [1:0]   w2c_valid_mac;
    logic         is_bb;
    logic [6:0]   bias_addr;
    logic [4:0]   bias_shift;
    logic         busy;
    logic [15:0]  inst_cnt;
    logic         idle_empty;

    inst_dispatch #(.INST_LEN(256), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instruct(instruct),
        .inst_empty(inst_empty), .inst_req(inst_req),
        .ilc_start(ilc_start), .ilc_done(ilc_done),
        .w2c_start(w2c_start), .w2c_done(w2c_done),
        .ilc_st_addr(ilc_st_addr), .ilc_ispad(ilc_ispad),
        .ilc_linelen(ilc_linelen), .bsr_iszero(bsr_iszero),
        .bsr_buffermux(bsr_buffermux), .ilc_fromfifo(ilc_fromfifo),
        .ilc_tofifo(ilc_tofifo), .is_w2c_back(is_w2c_back),
        .w2c_st_addr(w2c_st_addr), .w2c_linelen(w2c_linelen),
        .w2c_pooled(w2c_pooled), .pooled_type(pooled_type),
        .wb_st_rd_addr(wb_st_rd_addr), .w2c_shift_len(w2c_shift_len),
        .w2c_valid_mac(w2c_valid_mac), .is_bb(is_bb),
        .bias_addr(bias_addr), .bias_shift(bias_shift),
        .busy(busy), .inst_cnt(inst_cnt), .idle_empty(idle_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] word;
        int           ilc_dly;
        int           w2c_dly;
        int           exp_busy;
    } ent_t;

    ent_t fifo[$];
    ent_t expq[$];
    ent_t tbl[10];

    int n_cmp = 0;
    int n_bad = 0;
    int n_pops = 0;
    int n_starts = 0;
    int cyc = 0;
    int ilc_cd = -1;
    int w2c_cd = -1;
    int busy_len = 0;
    int cur_exp = 0;
    int last_end = -1;
    bit in_flight = 0;
    bit chk_gap = 0;

    logic [136:0] got_fields;
    assign got_fields = {bias_shift, bias_addr, is_bb, w2c_valid_mac,
                         w2c_shift_len, wb_st_rd_addr, pooled_type, w2c_pooled,
                         w2c_linelen, w2c_st_addr, is_w2c_back, ilc_tofifo,
                         ilc_fromfifo, bsr_buffermux, bsr_iszero, ilc_linelen,
                         ilc_ispad, ilc_st_addr};

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [255:0] rnd_word(input logic wb);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        w[60] = wb;
        return w;
    endfunction

    function automatic ent_t mk(input logic wb, input int idly, input int wdly, input int eb);
        ent_t e;
        e.word = rnd_word(wb);
        e.ilc_dly = idly;
        e.w2c_dly = wdly;
        e.exp_busy = eb;
        return e;
    endfunction

    task automatic refresh();
        inst_empty = (fifo.size() == 0);
        instruct   = inst_empty ? '0 : fifo[0].word;
    endtask

    task automatic push(input ent_t e);
        fifo.push_back(e);
        expq.push_back(e);
        refresh();
    endtask

    // One clock: monitor at negedge, FIFO pop and done responders after posedge.
    task automatic step();
        logic pop;
        ent_t e;
        @(negedge clk);
        pop = inst_req;
        if (pop) begin
            n_pops++;
            chk("req_only_in_idle", busy, 0);
        end
        if (ilc_start) begin
            n_starts++;
            if (expq.size() == 0) chk("start_without_word", 1, 0);
            else begin
                e = expq.pop_front();
                chk("fields", got_fields, e.word[136:0]);
                chk("w2c_start", w2c_start, e.word[60]);
                cur_exp = e.exp_busy;
            end
            if (chk_gap && last_end >= 0) chk("issue_gap", cyc - last_end, 1);
            in_flight = 1;
            busy_len = 0;
        end
        if (in_flight) begin
            if (busy) busy_len++;
            else begin
                chk("busy_len", busy_len, cur_exp);
                in_flight = 0;
                last_end = cyc;
            end
        end
        @(posedge clk);
        if (pop) begin
            e = fifo.pop_front();
            ilc_cd = e.ilc_dly;
            w2c_cd = e.w2c_dly;
        end
        #1;
        ilc_done = (ilc_cd == 0);
        w2c_done = (w2c_cd == 0);
        if (ilc_cd >= 0) ilc_cd--;
        if (w2c_cd >= 0) w2c_cd--;
        refresh();
        cyc++;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            step();
            if (fifo.size() == 0 && !in_flight && !busy) return;
        end
        chk("drain_timeout", 1, 0);
    endtask

    initial begin
        ent_t e;
        int base;
        rst_n = 1'b0;
        run = 1'b0;
        ilc_done = 1'b0;
        w2c_done = 1'b0;
        refresh();
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_cnt", inst_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ilc_start", ilc_start, 0);
        chk("rst_w2c_start", w2c_start, 0);
        chk("rst_fields", got_fields, 0);
        chk("rst_idle_empty", idle_empty, 1);

        // Single word, run held low first: no fetch.
        e = mk(1'b0, 5, -1, 6);
        e.word[35:0] = 36'h123456789;
        push(e);
        #1;
        chk("idle_empty_nonempty", idle_empty, 0);
        chk("req_run_low", inst_req, 0);
        step();
        step();
        chk("no_pop_run_low", n_pops, 0);

        // ILC-only word, done 5 cycles after ISSUE.
        run = 1'b1;
        drain(100);
        chk("one_pop", n_pops, 1);
        chk("one_start", n_starts, 1);
        chk("cnt_after_first", inst_cnt, 1);
        chk("idle_empty_end", idle_empty, 1);
        chk("st_addr_held", ilc_st_addr, 36'h123456789);

        // Back-to-back table: done orderings, same-cycle, done during ISSUE,
        // w2c_done ignored without write-back.
        tbl[0] = mk(1'b1, 4,  2, 5);   // w2c first, wait for ilc
        tbl[1] = mk(1'b1, 3,  3, 4);   // both same cycle
        tbl[2] = mk(1'b1, 0,  3, 4);   // ilc during ISSUE
        tbl[3] = mk(1'b1, 0,  0, 2);   // both during ISSUE
        tbl[4] = mk(1'b0, 2,  1, 3);   // stray w2c_done ignored
        tbl[5] = mk(1'b0, 1, -1, 2);
        tbl[6] = mk(1'b1, 1,  1, 2);
        tbl[7] = mk(1'b1, 2,  6, 7);   // ilc first, wait for w2c
        tbl[8] = mk(1'b0, 3,  0, 4);
        tbl[9] = mk(1'b1, 1,  1, 2);
        for (int i = 0; i < 10; i++) push(tbl[i]);
        base = n_pops;
        last_end = -1;
        chk_gap = 1;
        drain(300);
        chk_gap = 0;
        chk("tbl_pops", n_pops - base, 10);
        chk("tbl_starts", n_starts, 11);
        chk("tbl_cnt", inst_cnt, 11);

        // Dropping run mid-instruction finishes it but blocks the next fetch.
        push(mk(1'b0, 4, -1, 5));
        push(mk(1'b0, 1, -1, 2));
        step();
        step();
        run = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("runlow_pops", n_pops, 12);
        chk("runlow_cnt", inst_cnt, 12);
        chk("runlow_busy", busy, 0);
        chk("runlow_fifo", fifo.size(), 1);
        run = 1'b1;
        drain(50);
        chk("runlow_resume_cnt", inst_cnt, 13);

        // Reset while waiting on long-latency units.
        push(mk(1'b1, 20, 20, 21));
        step();
        step();
        step();
        chk("in_wait_busy", busy, 1);
        run = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_flight = 0;
        ilc_cd = -1;
        w2c_cd = -1;
        ilc_done = 1'b0;
        w2c_done = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", inst_cnt, 0);
        chk("midrst_fields", got_fields, 0);
        base = n_pops;
        push(mk(1'b0, 2, -1, 3));
        for (int i = 0; i < 4; i++) step();
        ilc_done = 1'b1;        // stray done in IDLE
        w2c_done = 1'b1;
        step();
        step();
        chk("midrst_no_pop", n_pops - base, 0);
        chk("idle_done_ignored", inst_cnt, 0);
        chk("idle_done_busy", busy, 0);
        run = 1'b1;
        drain(50);
        chk("post_rst_cnt", inst_cnt, 1);
        chk("scoreboard_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
